wb_result_arbiter: RTL and testbench

// Arbitrates among the execute-stage functional units (ALU, FPU, MULU, DIVU, FMULU, FDIVU,

---
 rtl/wb_result_arbiter.sv | 132 +++++++++++++
 tb/tb_wb_result_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/wb_result_arbiter.sv
// Execute-result arbiter: picks one finishing functional unit per cycle for the
// EX/MEM priority mux and returns a one-hot ack to the winning unit.
package wb_result_arbiter_pkg;
  typedef enum logic [2:0] {
    P_ALU       = 3'd0,
    P_FPU       = 3'd1,
    P_MULU      = 3'd2,
    P_DIVU      = 3'd3,
    P_FMULU     = 3'd4,
    P_FDIVU     = 3'd5,
    P_FADD_SUBU = 3'd6
  } priority_t;
endpackage

module wb_result_arbiter
  import wb_result_arbiter_pkg::*;
#(
  parameter int unsigned NUM_UNITS    = 7,
  parameter int unsigned AGE_W        = 4,
  parameter int unsigned STARVE_LIMIT = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_UNITS-1:0] unit_done,
  input  logic                 downstream_ready,
  input  logic                 flush,
  output priority_t            p_sel,
  output logic                 p_valid,
  output logic [NUM_UNITS-1:0] unit_ack,
  output logic                 ex_stall
);

  typedef enum logic {S_IDLE, S_HOLD} state_t;

  state_t                 state_q;
  priority_t              held_sel_q;
  logic [AGE_W-1:0]       age_q [NUM_UNITS];
  logic [AGE_W-1:0]       age_d [NUM_UNITS];
  logic [NUM_UNITS-1:0]   urgent;
  logic [NUM_UNITS-1:0]   cand;
  logic [NUM_UNITS-1:0]   sel_onehot;
  priority_t              winner;

  // Fixed base priority, highest first.
  function automatic priority_t pick(input logic [NUM_UNITS-1:0] v);
    if (v[P_DIVU])           return P_DIVU;
    else if (v[P_FDIVU])     return P_FDIVU;
    else if (v[P_MULU])      return P_MULU;
    else if (v[P_FMULU])     return P_FMULU;
    else if (v[P_FADD_SUBU]) return P_FADD_SUBU;
    else if (v[P_FPU])       return P_FPU;
    else                     return P_ALU;
  endfunction

  always_comb begin
    urgent = '0;
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      urgent[i] = unit_done[i] && (age_q[i] >= AGE_W'(STARVE_LIMIT));
    end
    cand   = (|urgent) ? urgent : unit_done;
    winner = pick(cand);
  end

  always_comb begin
    p_sel   = P_ALU;
    p_valid = 1'b0;
    if (!reset) begin
      if (state_q == S_HOLD) begin
        p_sel   = held_sel_q;
        p_valid = unit_done[held_sel_q];
      end else begin
        p_sel   = winner;
        p_valid = |unit_done;
      end
      if (flush) begin
        p_valid = 1'b0;
      end
    end
  end

  always_comb begin
    sel_onehot = NUM_UNITS'(1) << p_sel;
    unit_ack   = (p_valid && downstream_ready) ? sel_onehot : '0;
    ex_stall   = !reset && !flush && (|(unit_done & ~unit_ack));
  end

  always_comb begin
    for (int unsigned i = 0; i < NUM_UNITS; i++) begin
      age_d[i] = age_q[i];
      if (flush || unit_ack[i] || !unit_done[i]) begin
        age_d[i] = '0;
      end else if (age_q[i] != '1) begin
        age_d[i] = age_q[i] + AGE_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      held_sel_q <= P_ALU;
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        age_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NUM_UNITS; i++) begin
        age_q[i] <= age_d[i];
      end
      if (flush) begin
        state_q    <= S_IDLE;
        held_sel_q <= P_ALU;
      end else begin
        case (state_q)
          S_IDLE: begin
            if (p_valid && !downstream_ready) begin
              held_sel_q <= winner;
              state_q    <= S_HOLD;
            end
          end
          S_HOLD: begin
            // Leave on consume, or if the held unit withdrew its result.
            if (!unit_done[held_sel_q] || downstream_ready) begin
              state_q <= S_IDLE;
            end
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wb_result_arbiter.sv
module tb_wb_result_arbiter;
  import wb_result_arbiter_pkg::*;

  logic       clk;
  logic       reset;
  logic [6:0] unit_done;
  logic       downstream_ready;
  logic       flush;
  priority_t  p_sel;
  logic       p_valid;
  logic [6:0] unit_ack;
  logic       ex_stall;

  int unsigned total;
  int unsigned bad;

  wb_result_arbiter #(
    .NUM_UNITS   (7),
    .AGE_W       (4),
    .STARVE_LIMIT(8)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .unit_done       (unit_done),
    .downstream_ready(downstream_ready),
    .flush           (flush),
    .p_sel           (p_sel),
    .p_valid         (p_valid),
    .unit_ack        (unit_ack),
    .ex_stall        (ex_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input string tag, input logic [2:0] sel, input logic valid,
                            input logic [6:0] ack, input logic stall);
    chk({tag, ".p_sel"},    {5'b0, p_sel},    {5'b0, sel});
    chk({tag, ".p_valid"},  {7'b0, p_valid},  {7'b0, valid});
    chk({tag, ".unit_ack"}, {1'b0, unit_ack}, {1'b0, ack});
    chk({tag, ".ex_stall"}, {7'b0, ex_stall}, {7'b0, stall});
  endtask

  task automatic apply(input logic [6:0] d, input logic rdy, input logic fl);
    unit_done        = d;
    downstream_ready = rdy;
    flush            = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    unit_done = 7'h7F;
    downstream_ready = 1'b1;
    flush = 1'b0;
    #2;
    expect_out("rst_forced", 3'd0, 1'b0, 7'h00, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    apply(7'h00, 1'b1, 1'b0);
    expect_out("no_done", 3'd0, 1'b0, 7'h00, 1'b0);
    tick();

    // Reset while holding DIVU
    apply(7'h08, 1'b0, 1'b0);
    expect_out("t1_enter_hold", 3'd3, 1'b1, 7'h00, 1'b1);
    tick();
    reset = 1'b1;
    #1;
    expect_out("t1_async_rst", 3'd0, 1'b0, 7'h00, 1'b0);
    tick();
    reset = 1'b0;
    apply(7'h08, 1'b1, 1'b0);
    expect_out("t1_after_rst", 3'd3, 1'b1, 7'h08, 1'b0);
    tick();
    apply(7'h00, 1'b1, 1'b0);
    tick();

    // ALU + DIVU back to back
    apply(7'h09, 1'b1, 1'b0);
    expect_out("t2_c0", 3'd3, 1'b1, 7'h08, 1'b1);
    tick();
    apply(7'h01, 1'b1, 1'b0);
    expect_out("t2_c1", 3'd0, 1'b1, 7'h01, 1'b0);
    tick();
    apply(7'h00, 1'b1, 1'b0);
    tick();

    // HOLD on MULU ignores later DIVU
    apply(7'h04, 1'b0, 1'b0);
    expect_out("t3_c0", 3'd2, 1'b1, 7'h00, 1'b1);
    tick();
    apply(7'h0C, 1'b0, 1'b0);
    expect_out("t3_c1", 3'd2, 1'b1, 7'h00, 1'b1);
    tick();
    apply(7'h0C, 1'b0, 1'b0);
    expect_out("t3_c2", 3'd2, 1'b1, 7'h00, 1'b1);
    tick();
    apply(7'h0C, 1'b1, 1'b0);
    expect_out("t3_c3", 3'd2, 1'b1, 7'h04, 1'b1);
    tick();
    apply(7'h08, 1'b1, 1'b0);
    expect_out("t3_c4", 3'd3, 1'b1, 7'h08, 1'b0);
    tick();
    apply(7'h00, 1'b1, 1'b0);
    tick();

    // ALU starvation against a continuously done DIVU
    for (int c = 0; c < 8; c++) begin
      apply(7'h09, 1'b1, 1'b0);
      expect_out($sformatf("t4_c%0d", c), 3'd3, 1'b1, 7'h08, 1'b1);
      tick();
    end
    apply(7'h09, 1'b1, 1'b0);
    expect_out("t4_c8", 3'd0, 1'b1, 7'h01, 1'b1);
    tick();
    apply(7'h09, 1'b1, 1'b0);
    expect_out("t4_c9", 3'd3, 1'b1, 7'h08, 1'b1);
    tick();
    apply(7'h00, 1'b1, 1'b0);
    tick();

    // Flush clears ages and HOLD
    for (int c = 0; c < 9; c++) begin
      apply(7'h01, 1'b0, 1'b0);
      tick();
    end
    apply(7'h7F, 1'b1, 1'b1);
    chk("t5_flush.p_valid",  {7'b0, p_valid},  8'h00);
    chk("t5_flush.unit_ack", {1'b0, unit_ack}, 8'h00);
    chk("t5_flush.ex_stall", {7'b0, ex_stall}, 8'h00);
    tick();
    apply(7'h09, 1'b1, 1'b0);
    expect_out("t5_post", 3'd3, 1'b1, 7'h08, 1'b1);
    tick();
    apply(7'h00, 1'b1, 1'b0);
    tick();

    // Held FDIVU withdraws its done
    apply(7'h20, 1'b0, 1'b0);
    expect_out("t6_c0", 3'd5, 1'b1, 7'h00, 1'b1);
    tick();
    apply(7'h01, 1'b0, 1'b0);
    expect_out("t6_c1", 3'd5, 1'b0, 7'h00, 1'b1);
    tick();
    apply(7'h01, 1'b1, 1'b0);
    expect_out("t6_c2", 3'd0, 1'b1, 7'h01, 1'b0);
    tick();
    apply(7'h00, 1'b1, 1'b0);
    expect_out("idle_end", 3'd0, 1'b0, 7'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
